// File: rtl/cpu_pkg.sv
// Shared types for the EX-stage branch unit: branch kinds, ARM condition codes,
// the NZCV flag struct and the branch FSM state encoding.
package cpu_pkg;

   typedef enum logic [1:0] {
      BR_B     = 2'b00,
      BR_BCOND = 2'b01,
      BR_CBZ   = 2'b10,
      BR_CBNZ  = 2'b11
   } br_kind_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_HS = 4'b0010,
      COND_LO = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SQUASH = 2'b01,
      ST_WAIT   = 2'b10
   } state_t;

   // Only conditional branches read NZCV; CBZ/CBNZ/B never wait on flags.
   function automatic logic reads_flags(br_kind_t kind);
      return kind == BR_BCOND;
   endfunction

endpackage

// File: rtl/cond_branch_unit_if.sv
// ALU-flag, branch-request and fetch-redirect signals between EX and the branch unit.
// The master drives ALU results and branch requests; the slave is the branch unit.
interface cond_branch_unit_if #(
   parameter int DATA_W = 64
);
   import cpu_pkg::*;

   logic              alu_valid;
   logic              alu_set_flags;
   logic              alu_negative;
   logic              alu_zero;
   logic              alu_carry_out;
   logic              alu_overflow;

   logic              br_valid;
   br_kind_t          br_kind;
   cond_t             br_cond;
   logic [DATA_W-1:0] br_rt_val;
   logic [DATA_W-1:0] br_pc;
   logic [DATA_W-1:0] br_imm;
   logic              br_ready;

   logic              redirect;
   logic [DATA_W-1:0] redirect_pc;
   logic              flush;
   flags_t            flags_q;

   modport master (
      output alu_valid, alu_set_flags, alu_negative, alu_zero, alu_carry_out, alu_overflow,
      output br_valid, br_kind, br_cond, br_rt_val, br_pc, br_imm,
      input  br_ready, redirect, redirect_pc, flush, flags_q
   );

   modport slave (
      input  alu_valid, alu_set_flags, alu_negative, alu_zero, alu_carry_out, alu_overflow,
      input  br_valid, br_kind, br_cond, br_rt_val, br_pc, br_imm,
      output br_ready, redirect, redirect_pc, flush, flags_q
   );

endinterface

// File: rtl/cond_branch_unit_cond_eval.sv
// Combinational ARM condition-code evaluator: (flags, cond) -> take.
module cond_eval
   import cpu_pkg::*;
(
   input  flags_t flags,
   input  cond_t  cond,
   output logic   take
);

   logic [3:0] cond_bits;
   logic       base;

   assign cond_bits = cond;

   // Odd encodings are the complement of the even one below them, except AL/NV.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      base = 1'b0;
      case (cond_bits[3:1])
         3'b000:  base = flags.z;
         3'b001:  base = flags.c;
         3'b010:  base = flags.n;
         3'b011:  base = flags.v;
         3'b100:  base = flags.c & ~flags.z;
         3'b101:  base = (flags.n == flags.v);
         3'b110:  base = ~flags.z & (flags.n == flags.v);
         default: base = 1'b1;
      endcase
   end

   assign take = (cond_bits[3:1] == 3'b111) ? 1'b1 : (base ^ cond_bits[0]);

endmodule

// File: rtl/cond_branch_unit.sv
// EX-stage NZCV flag register and branch resolver with a one-cycle redirect/flush.
// Define FLAG_FWD_EN to bypass same-cycle ALU flags into B.cond instead of stalling.
module cond_branch_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input logic               clk,
   input logic               reset_n,
   cond_branch_unit_if.slave bus
);

   state_t            state_q;
   state_t            state_d;
   flags_t            flags_q;
   flags_t            alu_flags;
   flags_t            eval_flags;
   logic              alu_upd;
   logic              hazard;
   logic              cond_take;
   logic              kind_take;
   logic              take;
   logic              br_ready;
   logic              redirect_q;
   logic              flush_q;
   logic [DATA_W-1:0] target;
   logic [DATA_W-1:0] redirect_pc_q;

   assign alu_upd   = bus.alu_valid & bus.alu_set_flags;
   assign alu_flags = '{n: bus.alu_negative, z: bus.alu_zero,
                        c: bus.alu_carry_out, v: bus.alu_overflow};

`ifdef FLAG_FWD_EN
   assign eval_flags = alu_upd ? alu_flags : flags_q;
   assign hazard     = 1'b0;
`else
   // A flag-setting op ahead of B.cond in the same cycle stalls it one cycle
   // so the branch reads the freshly written flags_q.
   assign eval_flags = flags_q;
   assign hazard     = bus.br_valid & reads_flags(bus.br_kind) & alu_upd;
`endif

   cond_eval u_cond_eval (
      .flags (eval_flags),
      .cond  (bus.br_cond),
      .take  (cond_take)
   );

   // Wraps modulo 2^DATA_W by construction.
   assign target = bus.br_pc + {bus.br_imm[DATA_W-3:0], 2'b00};

   always_comb begin
      kind_take = 1'b0;
      case (bus.br_kind)
         BR_B:     kind_take = 1'b1;
         BR_BCOND: kind_take = cond_take;
         BR_CBZ:   kind_take = (bus.br_rt_val == '0);
         BR_CBNZ:  kind_take = (bus.br_rt_val != '0);
         default:  kind_take = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      br_ready = 1'b1;
      take     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hazard) begin
               br_ready = 1'b0;
               state_d  = ST_WAIT;
            end else begin
               take = bus.br_valid & kind_take;
               if (take) state_d = ST_SQUASH;
            end
         end
         // Wrong-path branch: accepted and dropped.
         ST_SQUASH: state_d = ST_IDLE;
         ST_WAIT: begin
            take    = bus.br_valid & kind_take;
            state_d = take ? ST_SQUASH : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         flags_q       <= '0;
         redirect_q    <= 1'b0;
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         if (alu_upd) flags_q <= alu_flags;
         redirect_q    <= take;
         flush_q       <= take;
         redirect_pc_q <= take ? target : '0;
      end
   end

   assign bus.br_ready    = br_ready;
   assign bus.redirect    = redirect_q;
   assign bus.flush       = flush_q;
   assign bus.redirect_pc = redirect_pc_q;
   assign bus.flags_q     = flags_q;

endmodule
